// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - decode inputs and control outputs between controller and datapath
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [3:0] Flag;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       Retire;
  logic       Halt;

  modport master (
    input  op, funct3, funct7b5, Flag, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Retire, Halt
  );

  modport slave (
    output op, funct3, funct7b5, Flag, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Retire, Halt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V style main controller FSM
module multicycle_ctrl (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR, LUI, HALT
  } state_t;

  state_t     state, state_next;
  logic       retire_q;
  logic       taken;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       unused_funct7b5;

  assign unused_funct7b5 = bus.funct7b5;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      retire_q <= 1'b0;
    end else begin
      state    <= state_next;
      retire_q <= (state_next == FETCH) && (state != FETCH);
    end
  end

  // Flag = {Ovf, Carry, Neg, Zero}
  always_comb begin
    taken = 1'b0;
    case (bus.funct3)
      3'b000:  taken = bus.Flag[0];
      3'b001:  taken = ~bus.Flag[0];
      3'b100:  taken = bus.Flag[1] ^ bus.Flag[3];
      3'b101:  taken = ~(bus.Flag[1] ^ bus.Flag[3]);
      3'b110:  taken = ~bus.Flag[2];
      3'b111:  taken = bus.Flag[2];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
        if (bus.MemReady) state_next = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          7'b0000011, 7'b0100011: state_next = MEMADR;
          7'b0110011:             state_next = EXECR;
          7'b0010011:             state_next = EXECI;
          7'b1100011:             state_next = BRANCH;
          7'b1101111:             state_next = JAL;
          7'b1100111:             state_next = JALR;
          7'b0110111:             state_next = LUI;
          // funct3=000 in the system space is taken as EBREAK; other system ops retire as no-ops
          7'b1110011:             state_next = (bus.funct3 == 3'b000) ? HALT : FETCH;
          default:                state_next = HALT;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (bus.MemReady) state_next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.MemReady) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = taken;
        state_next = FETCH;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
      // JALR loads rs1+imm, then reuses JAL to form OldPC+4 for the link write
      JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_next = JAL;
      end
      LUI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = ALUWB;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  assign bus.PCWrite   = pc_write & ~reset;
  assign bus.IRWrite   = ir_write & ~reset;
  assign bus.MemWrite  = mem_write & ~reset;
  assign bus.RegWrite  = reg_write & ~reset;
  assign bus.Retire    = retire_q & ~reset;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.Halt      = (state == HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Retire, Halt}
  logic [14:0] ctl;
  assign ctl = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.Retire, bus.Halt};

  function automatic logic [14:0] w(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] aop, input logic ret, input logic hlt);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, ret, hlt};
  endfunction

  localparam logic [14:0] F_RDY   = w(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0);
  localparam logic [14:0] F_WAIT  = w(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0);
  localparam logic [14:0] F_RET   = w(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00,1'b1,1'b0);
  localparam logic [14:0] FW_RET  = w(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b1,1'b0);
  localparam logic [14:0] RST     = F_WAIT;
  localparam logic [14:0] DEC     = w(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b0);
  localparam logic [14:0] MADR    = w(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0,1'b0);
  localparam logic [14:0] MRD     = w(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0);
  localparam logic [14:0] MWB     = w(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,1'b0,1'b0);
  localparam logic [14:0] MWR     = w(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0);
  localparam logic [14:0] EXR     = w(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0);
  localparam logic [14:0] EXI     = w(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,1'b0,1'b0);
  localparam logic [14:0] AWB     = w(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0);
  localparam logic [14:0] BR_T    = w(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0,1'b0);
  localparam logic [14:0] BR_N    = w(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0,1'b0);
  localparam logic [14:0] JALW    = w(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0);
  localparam logic [14:0] JALRW   = w(1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,2'b10,2'b01,2'b00,1'b0,1'b0);
  localparam logic [14:0] LUIW    = w(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0,1'b0);
  localparam logic [14:0] HLT     = w(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1);

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  // drive MemReady, check this cycle's controls away from the edge, then advance one cycle
  task automatic cyc(input logic mr, input logic [14:0] exp, input string tag);
    bus.MemReady = mr;
    #1;
    check(tag, ctl, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.MemReady = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_state", ctl, RST);
    reset = 1'b0;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [3:0] fl);
    bus.op       = o;
    bus.funct3   = f3;
    bus.funct7b5 = 1'b1;
    bus.Flag     = fl;
  endtask

  task automatic branch_case(input logic [2:0] f3, input logic [3:0] fl,
                             input logic [14:0] exp, input string tag);
    set_instr(7'b1100011, f3, fl);
    do_reset();
    cyc(1'b1, F_RDY, "br_fetch");
    cyc(1'b1, DEC, "br_decode");
    cyc(1'b1, exp, tag);
    cyc(1'b0, FW_RET, "br_retire");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_instr(7'b0110011, 3'b000, 4'b0000);
    bus.MemReady = 1'b1;

    // R-type with MemReady held high (ignored outside memory states)
    do_reset();
    cyc(1'b1, F_RDY, "r_fetch");
    cyc(1'b1, DEC, "r_decode");
    cyc(1'b1, EXR, "r_execr");
    cyc(1'b1, AWB, "r_aluwb");
    cyc(1'b0, FW_RET, "r_retire");
    cyc(1'b0, F_WAIT, "r_retire_once");

    // lw with a three-cycle memory stall
    set_instr(7'b0000011, 3'b010, 4'b0000);
    do_reset();
    cyc(1'b0, F_WAIT, "lw_fetch_wait");
    cyc(1'b1, F_RDY, "lw_fetch");
    cyc(1'b1, DEC, "lw_decode");
    cyc(1'b1, MADR, "lw_memadr");
    for (int i = 0; i < 3; i++) cyc(1'b0, MRD, "lw_memread_wait");
    cyc(1'b1, MRD, "lw_memread_done");
    cyc(1'b0, MWB, "lw_memwb");
    cyc(1'b0, FW_RET, "lw_retire");

    // branch condition table
    branch_case(3'b000, 4'b0001, BR_T, "beq_taken");
    branch_case(3'b000, 4'b0000, BR_N, "beq_not_taken");
    branch_case(3'b110, 4'b0000, BR_T, "bltu_taken");
    branch_case(3'b111, 4'b0000, BR_N, "bgeu_not_taken");
    branch_case(3'b100, 4'b1010, BR_N, "blt_ovf_neg");
    branch_case(3'b101, 4'b1010, BR_T, "bge_ovf_neg");
    branch_case(3'b001, 4'b0000, BR_T, "bne_taken");
    branch_case(3'b010, 4'b1111, BR_N, "f3_010_never");

    // sw completing on its second MEMWRITE cycle
    set_instr(7'b0100011, 3'b010, 4'b0000);
    do_reset();
    cyc(1'b1, F_RDY, "sw_fetch");
    cyc(1'b1, DEC, "sw_decode");
    cyc(1'b1, MADR, "sw_memadr");
    cyc(1'b0, MWR, "sw_memwrite_1");
    cyc(1'b1, MWR, "sw_memwrite_2");
    cyc(1'b0, FW_RET, "sw_retire");

    // I-type, JAL, JALR, LUI
    set_instr(7'b0010011, 3'b000, 4'b0000);
    do_reset();
    cyc(1'b1, F_RDY, "i_fetch");
    cyc(1'b1, DEC, "i_decode");
    cyc(1'b1, EXI, "i_execi");
    cyc(1'b1, AWB, "i_aluwb");
    cyc(1'b0, FW_RET, "i_retire");

    set_instr(7'b1101111, 3'b000, 4'b0000);
    do_reset();
    cyc(1'b1, F_RDY, "jal_fetch");
    cyc(1'b1, DEC, "jal_decode");
    cyc(1'b1, JALW, "jal_jal");
    cyc(1'b1, AWB, "jal_aluwb");
    cyc(1'b0, FW_RET, "jal_retire");

    set_instr(7'b1100111, 3'b000, 4'b0000);
    do_reset();
    cyc(1'b1, F_RDY, "jalr_fetch");
    cyc(1'b1, DEC, "jalr_decode");
    cyc(1'b1, JALRW, "jalr_jalr");
    cyc(1'b1, JALW, "jalr_jal");
    cyc(1'b1, AWB, "jalr_aluwb");
    cyc(1'b0, FW_RET, "jalr_retire");

    set_instr(7'b0110111, 3'b000, 4'b0000);
    do_reset();
    cyc(1'b1, F_RDY, "lui_fetch");
    cyc(1'b1, DEC, "lui_decode");
    cyc(1'b1, LUIW, "lui_lui");
    cyc(1'b1, AWB, "lui_aluwb");
    cyc(1'b0, FW_RET, "lui_retire");

    // system ops: funct3=000 halts, others retire straight from DECODE
    set_instr(7'b1110011, 3'b001, 4'b0000);
    do_reset();
    cyc(1'b1, F_RDY, "csr_fetch");
    cyc(1'b1, DEC, "csr_decode");
    cyc(1'b0, FW_RET, "csr_retire");

    set_instr(7'b1110011, 3'b000, 4'b0000);
    do_reset();
    cyc(1'b1, F_RDY, "ebreak_fetch");
    cyc(1'b1, DEC, "ebreak_decode");
    cyc(1'b1, HLT, "ebreak_halt");

    // illegal opcode halts and stays halted until reset
    set_instr(7'b0000000, 3'b000, 4'b0000);
    do_reset();
    cyc(1'b1, F_RDY, "ill_fetch");
    cyc(1'b1, DEC, "ill_decode");
    for (int i = 0; i < 10; i++) cyc(1'(i % 2), HLT, "ill_halt_hold");
    do_reset();
    cyc(1'b0, F_WAIT, "halt_cleared");

    // reset during a pending MEMREAD
    set_instr(7'b0000011, 3'b010, 4'b0000);
    do_reset();
    cyc(1'b1, F_RDY, "rmr_fetch");
    cyc(1'b1, DEC, "rmr_decode");
    cyc(1'b0, MADR, "rmr_memadr");
    bus.MemReady = 1'b1;
    reset = 1'b1;
    #1;
    check("rmr_memread_in_reset", ctl, MRD);
    @(posedge clk);
    #1;
    check("rmr_fetch_after_reset", ctl, RST);
    reset = 1'b0;
    cyc(1'b0, F_WAIT, "rmr_no_retire");
    cyc(1'b0, F_WAIT, "rmr_no_regwrite");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Ports SHALL be as follows.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-high.
- op  in  7  opcode from instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- Flag  in  4  {Ovf, Carry, Neg, Zero} from ALU.
- MemReady  in  1  unified memory done strobe.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction/OldPC register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = subtract (compare), 10 = funct decode.
- Retire  out  1  one-cycle pulse per completed instruction.
- Halt  out  1  sticky stop indication.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.

Function
REQ-003 The FSM SHALL use these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, HALT.
REQ-004 Outputs SHALL be Moore-decoded from state, except PCWrite, IRWrite and MemWrite, which are also gated as stated below; unlisted outputs are 0.
REQ-005 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- IRWrite=PCWrite=MemReady.
- Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
REQ-006 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 -> LUI
- 1110011 -> HALT if funct3=000 and instr is EBREAK (funct7b5 ignored; Ebreak qualified by funct3=000, op=1110011 and a nonzero immediate treated as EBREAK), otherwise FETCH
- any other op -> HALT
REQ-007 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
REQ-008 MEMREAD: ResultSrc=00, AdrSrc=1. Holds until MemReady=1, then -> MEMWB.
REQ-009 MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-010 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 while waiting. Holds until MemReady=1, then -> FETCH; MemWrite SHALL deassert the cycle after MemReady.
REQ-011 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
REQ-012 EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
REQ-013 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-014 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=taken, then -> FETCH. taken by funct3:
- 000: Zero
- 001: !Zero
- 100: Neg^Ovf
- 101: !(Neg^Ovf)
- 110: !Carry
- 111: Carry
- 010, 011: 0
REQ-015 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB (rd gets OldPC+4).
REQ-016 JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCWrite=1 -> JAL-equivalent writeback: ALUSrcA=01, ALUSrcB=10 computed in ALUWB path via a second JAL state visit. Target bit 0 is cleared by the datapath.
REQ-017 LUI: ALUSrcA=10 with datapath forcing rs1=x0, ALUSrcB=01, ALUOp=00 -> ALUWB.
REQ-018 HALT: all enables 0, Halt=1; remains in HALT until reset.
REQ-019 Retire SHALL pulse for one cycle on every transition into FETCH from a non-FETCH state.
REQ-020 MemReady SHALL be ignored in all states other than FETCH, MEMREAD and MEMWRITE.

Reset
REQ-021 When reset=1 at a rising edge, the state SHALL become FETCH, regardless of the current state (including HALT or a pending memory wait).
REQ-022 While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and Retire SHALL be forced to 0 combinationally; Halt SHALL be 0 after reset.

Verification
REQ-023 Benches SHALL cover these scenarios:
- reset, MemReady=1, op=0110011 -> state sequence FETCH, DECODE, EXECR, ALUWB, FETCH; RegWrite=1 in the 4th cycle only; Retire pulse in the 5th cycle.
- lw with MemReady held 0 for 3 cycles in MEMREAD -> AdrSrc=1 for 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1.
- beq with Flag=0001 -> PCWrite=1 in BRANCH; with Flag=0000 -> PCWrite=0; bltu with Flag=0000 -> PCWrite=1.
- sw, MemReady=1 on the 2nd MEMWRITE cycle -> MemWrite high exactly 2 cycles, then FETCH.
- op=0000000 -> HALT, Halt=1 held for 10 cycles; reset -> FETCH, Halt=0.
- reset asserted mid-MEMREAD -> FETCH next cycle, with no RegWrite issued.
